// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage buffers.
//   ps_state_e  : occupancy state of a stage buffer (EMPTY / ONE / TWO)
//   XLEN        : default payload width
//   PERF_CNT_W  : default width of stage performance counters
package pipe_pkg;

   localparam int XLEN       = 32;
   localparam int PERF_CNT_W = 16;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } ps_state_e;

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   stg_clk : clock, rising edge
//   reset   : asynchronous, active-high; clears the count
//   inc     : add one this cycle (ignored once the count is all ones)
//   clr     : synchronous clear, wins over inc
//   cnt     : current count
module sat_counter
   import pipe_pkg::*;
#(
   parameter int W = PERF_CNT_W
) (
   input  logic         stg_clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !(&cnt_q)) begin
         // Stop at all ones; never wrap back to zero.
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge stg_clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: pipeline stage register with a one-entry skid buffer,
// synchronous flush and a saturating stall counter.
//   stg_clk / reset        : clock (rising edge), async active-high reset
//   in_valid/in_data       : upstream beat
//   in_ready               : stage can accept (registered)
//   out_valid/out_data     : beat held in the main register
//   out_ready              : downstream accepts
//   flush                  : drop every held and incoming beat this cycle
//   stall_cnt              : cycles with out_valid && !out_ready (saturating)
//   stall_cnt_clr          : synchronous clear of stall_cnt
//   dbg_state              : current occupancy state
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid may not depend on ready, and a presented beat stays stable
// until it transfers. in_ready is a register output, so upstream never sees
// a combinational path from out_ready.
module pipe_stage_buffer
   import pipe_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int CNT_W  = PERF_CNT_W
) (
   input  logic              stg_clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_cnt_clr,
   output ps_state_e         dbg_state
);

   ps_state_e         state_q;
   ps_state_e         state_d;
   logic [DATA_W-1:0] main_data_q;
   logic [DATA_W-1:0] main_data_d;
   logic [DATA_W-1:0] skid_data_q;
   logic [DATA_W-1:0] skid_data_d;

   logic main_v;
   logic skid_v;
   logic accept;
   logic emit;

   // The state register is the single source of main_v / skid_v.
   assign main_v = (state_q == PS_ONE) || (state_q == PS_TWO);
   assign skid_v = (state_q == PS_TWO);

   assign in_ready  = !skid_v;
   assign out_valid = main_v;
   assign out_data  = main_data_q;
   assign dbg_state = state_q;

   assign accept = in_valid && in_ready;
   assign emit   = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;

      if (flush) begin
         // Drop everything, including a beat accepted this cycle. The data
         // registers are left stale; they are masked by the valid bits.
         state_d = PS_EMPTY;
      end else begin
         unique case (state_q)
            PS_EMPTY: begin
               if (accept) begin
                  main_data_d = in_data;
                  state_d     = PS_ONE;
               end
            end
            PS_ONE: begin
               if (accept && emit) begin
                  main_data_d = in_data;
               end else if (accept) begin
                  // Downstream stalled: park the in-flight beat in skid.
                  skid_data_d = in_data;
                  state_d     = PS_TWO;
               end else if (emit) begin
                  state_d = PS_EMPTY;
               end
            end
            PS_TWO: begin
               // in_ready is low here, so only the drain path exists.
               if (emit) begin
                  main_data_d = skid_data_q;
                  state_d     = PS_ONE;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean empty stage.
               state_d = PS_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge stg_clk or posedge reset) begin
      if (reset) begin
         state_q     <= PS_EMPTY;
         main_data_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .stg_clk (stg_clk),
      .reset   (reset),
      .inc     (out_valid && !out_ready),
      .clr     (stall_cnt_clr),
      .cnt     (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;
  import pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              stg_clk;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_cnt_clr;
  ps_state_e         dbg_state;

  // reference model: queue of held beats (oldest first) and stall count
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [CNT_W-1:0]  exp_cnt;

  int n_checks;
  int n_errors;

  pipe_stage_buffer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .stg_clk       (stg_clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .flush         (flush),
    .stall_cnt     (stall_cnt),
    .stall_cnt_clr (stall_cnt_clr),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial stg_clk = 1'b0;
  always #5 stg_clk = ~stg_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: compare outputs against the model, drive inputs, advance the
  // model across the rising edge. Called just after a falling edge.
  task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                      input logic fl, input logic clr);
    logic m_valid, m_ready, acc, emt;
    m_valid = (exp_q.size() > 0);
    m_ready = (exp_q.size() < 2);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("state", {30'd0, dbg_state}, exp_q.size());
    if (m_valid) chk("out_data", out_data, exp_q[0]);
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_cnt});
    acc = iv && m_ready;
    emt = m_valid && ordy;
    if (emt) got_q.push_back(out_data);
    in_valid      = iv;
    in_data       = id;
    out_ready     = ordy;
    flush         = fl;
    stall_cnt_clr = clr;
    @(posedge stg_clk);
    if (emt) void'(exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(id);
    if (clr) exp_cnt = '0;
    else if (m_valid && !ordy && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    @(negedge stg_clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; stall_cnt_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = '0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge stg_clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    @(negedge stg_clk);

    // streaming at full rate
    got_q.delete();
    step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    chk("stream_lat1", {31'd0, out_valid}, 32'd1);
    step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk("stream_0", got_q[0], 32'h11);
      chk("stream_1", got_q[1], 32'h22);
      chk("stream_2", got_q[2], 32'h33);
    end

    // back-pressure into the skid
    got_q.delete();
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_main", out_data, 32'hA);
    step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk("bp_0", got_q[0], 32'hA);
      chk("bp_1", got_q[1], 32'hB);
      chk("bp_2", got_q[2], 32'hC);
    end

    // flush while full with a beat arriving
    step(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
    got_q.delete();
    step(1'b1, 32'hD3, 1'b0, 1'b1, 1'b0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    drain();
    chk("flush_none_out", got_q.size(), 32'd0);

    // asynchronous reset while full
    step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge stg_clk);
    reset = 1'b0;
    @(negedge stg_clk);

    // long stall saturates the counter
    step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge stg_clk);
      if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    end
    @(negedge stg_clk);
    chk("stall_sat", {16'd0, stall_cnt}, 32'd65535);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("stall_clr_zero", {16'd0, stall_cnt}, 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_clr_one", {16'd0, stall_cnt}, 32'd1);
    drain();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline stage register, the successor of the fixed-field stage latches between fetch/decode/execute. It carries an opaque `DATA_W`-bit payload with a valid/ready handshake, adds a one-entry skid buffer so back-pressure never drops or duplicates an instruction, and provides a synchronous flush for branch mispredictions. A saturating stall counter supports pipeline performance analysis.

## Interface
- `DATA_W`, 32: payload width in bits; upstream packs pc/rs/rd/imm/control fields.
- `CNT_W`, 16: stall counter width.
- `stg_clk`  in  1  stage clock; all state updates on the rising edge.
- `reset`  in  1  reset: asynchronous, active-high.
- `in_valid`  in  1  upstream beat present.
- `in_data`  in  DATA_W  upstream payload.
- `in_ready`  out  1  stage can accept; registered, not combinationally dependent on `out_ready`.
- `out_valid`  out  1  beat present at output.
- `out_data`  out  DATA_W  output payload.
- `out_ready`  in  1  downstream accepts.
- `flush`  in  1  discard every held and incoming beat this cycle.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`; saturates.
- `stall_cnt_clr`  in  1  synchronous clear of `stall_cnt`.

## Operation
- Storage: main register (`main_v`, `main_d`) drives the outputs; skid register (`skid_v`, `skid_d`) holds one overflow beat.
- States: EMPTY (`main_v=0`), ONE (`main_v=1, skid_v=0`), TWO (both valid). SKID-only is illegal.
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- `in_ready = !skid_v`, taken from the register.
- EMPTY: accept, main loads `in_data` -> ONE.
- ONE: accept and emit, main loads `in_data` and stays ONE; accept without emit, skid loads `in_data` -> TWO; emit without accept -> EMPTY.
- TWO: emit, main loads `skid_d`, skid cleared -> ONE. No accept is possible.
- `flush=1`: `main_v` and `skid_v` cleared -> EMPTY regardless of every other input. A beat accepted in the same cycle is discarded. Data registers keep their stale contents.
- `out_data` is meaningful only while `out_valid=1`.
- Stall counter: increments by 1 each cycle with `out_valid && !out_ready`, saturating at 2^CNT_W-1 with no wrap. `stall_cnt_clr` has priority over the increment. `flush` does not affect the counter.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `out_data=0`, `stall_cnt=0`, `skid_d=0`, state EMPTY.
- Reset may assert mid-transfer; held beats are lost with no partial output.
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data` after edge N, 1 cycle.
- Throughput: 1 beat/cycle sustained while `out_ready=1`.
- Back-pressure propagates upstream one cycle late. `in_ready` falls after the edge that fills skid. The skid absorbs the beat in flight.
- `in_ready` rises the cycle after the emit that drains skid.
- Ordering is strict FIFO: main always holds the oldest beat.
- Flush takes effect on the next edge: `out_valid=0` and `in_ready=1` after that edge.

## Structure
- Shared package `pipe_pkg`: state encoding `PS_EMPTY=2'd0`, `PS_ONE=2'd1`, `PS_TWO=2'd2`, and the default widths `XLEN=32` and `PERF_CNT_W=16`.
- One natural sub-module: `sat_counter` (parameter `W`; inputs `inc`, `clr`; output `cnt`). It is reused by other stage performance counters.
- The skid datapath stays inline.

## Test plan
- Reset with no traffic -> `out_valid=0`, `in_ready=1`, `out_data=0`, `stall_cnt=0`. Assert `reset` mid-TWO state -> same values immediately.
- Stream 0x11,0x22,0x33 with `out_ready=1` -> the same three values on `out_valid` cycles 1-3, one cycle late, no gaps.
- Feed 0xA,0xB,0xC while `out_ready=0` -> 0xA in main, 0xB in skid, `in_ready=0` after edge 2, 0xC held upstream. Release `out_ready` -> output order 0xA,0xB,0xC with none lost or duplicated.
- In TWO state assert `flush` with `in_valid=1` -> next cycle `out_valid=0`, `in_ready=1`, and none of the three beats ever appear.
- Hold `out_valid=1, out_ready=0` for 70000 cycles with CNT_W=16 -> `stall_cnt=65535`. Pulse `stall_cnt_clr` while still stalled -> 0 then 1.
- Random `in_valid`/`out_ready`/`flush` against a scoreboard -> every emitted beat matches the FIFO order of accepted non-flushed beats.
